// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] i_d);
    return ^i_d;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte request handshake for the two requesters sharing the UART TX line.
interface uart_tx_arbiter_if;
  import uart_pkg::*;

  logic                 req0_valid;
  logic [DATA_BITS-1:0] req0_data;
  logic                 req0_ready;
  logic                 req1_valid;
  logic [DATA_BITS-1:0] req1_data;
  logic                 req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/uart_tx_arbiter_timer.sv
// Bit-period counter: counts 0..DIVISOR-1 and wraps, flagging the last clock
// of every bit period. i_restart holds it at zero (used while the line idles).
module uart_bit_timer #(
  parameter int DIVISOR = 434,
  parameter int CNT_W   = 9
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] r_cnt;

  // Free-running bit counter with synchronous clear on restart or wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LP_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LP_LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter plus 8N1 serialiser sharing one UART TX pin between two
// byte requesters. Optional feature macro: UART_PARITY_EN adds an even-parity
// bit between the last data bit and the stop bit.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 115200,
  parameter int DIVISOR = CLK_HZ / BAUD,
  parameter int CNT_W   = 9
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_grant_id
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(DATA_BITS - 1);

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_grant;
`ifdef UART_PARITY_EN
  logic                 r_par;
`endif

  logic                 w_tick;
  logic                 w_restart;
  logic                 w_rdy0;
  logic                 w_rdy1;
  logic                 w_accept;
  logic [DATA_BITS-1:0] w_data;

  // Timer is held at zero while idle so each frame's START begins a full period.
  assign w_restart = (r_state == ST_IDLE);

  uart_bit_timer #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  // Readies only in IDLE; on contention the requester that did not own the last frame wins.
  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    if (r_state == ST_IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (r_grant) w_rdy0 = 1'b1;
        else         w_rdy1 = 1'b1;
      end else if (bus.req0_valid) begin
        w_rdy0 = 1'b1;
      end else if (bus.req1_valid) begin
        w_rdy1 = 1'b1;
      end
    end
  end

  assign w_accept       = w_rdy0 | w_rdy1;
  assign w_data         = w_rdy1 ? bus.req1_data : bus.req0_data;
  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;

  // Frame sequencer: accepts a byte in IDLE, then emits start, data (LSB first), [parity], stop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_tx    <= IDLE_LEVEL;
      r_busy  <= 1'b0;
      r_grant <= 1'b1;
`ifdef UART_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift <= w_data;
            r_grant <= w_rdy1;
            r_idx   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_START;
`ifdef UART_PARITY_EN
            r_par   <= even_parity(w_data);
`endif
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_idx == LP_LAST_IDX) begin
`ifdef UART_PARITY_EN
              r_tx    <= r_par;
              r_state <= ST_PARITY;
`else
              r_tx    <= IDLE_LEVEL;
              r_state <= ST_STOP;
`endif
            end else begin
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= IDLE_LEVEL;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_tx    <= IDLE_LEVEL;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= IDLE_LEVEL;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx       = r_tx;
  assign o_busy     = r_busy;
  assign o_grant_id = r_grant;

endmodule
